wb_result_select: RTL and testbench
===================================

// Module: wb_result_select
// PURPOSE
//  Parametrised, pipelined writeback result selector for the 16-bit datapath.
//  Picks one of N_SRC operand sources (ALU, data memory, PC, ...) by a select code.
//  Registers the chosen result with its destination register through a 2-entry skid buffer.
//  Sits between the execute/memory stages and the register-bank write port.
//  Adds valid/ready flow control and illegal-select detection.
// PARAMETERS
//  WIDTH    16  data width of every source and of the result
//  N_SRC    3   number of selectable sources (>=2)
//  SEL_W    2   select code width; must satisfy 2**SEL_W >= N_SRC
//  DEST_W   3   destination register address width
//  ERR_CW   8   width of the saturating illegal-select counter
// PORTS
//  clk          in   1             rising-edge clock
//  rst_n        in   1             synchronous reset, active-low
//  in_valid     in   1             source bundle valid
//  in_ready     out  1             stage can accept (registered, = !full)
//  in_sel       in   SEL_W         source select code
//  in_src       in   N_SRC*WIDTH   packed sources, index k at [k*WIDTH +: WIDTH]
//  in_dest      in   DEST_W        destination register address
//  out_valid    out  1             result valid toward register bank
//  out_ready    in   1             register bank accepts
//  out_data     out  WIDTH         selected result
//  out_dest     out  DEST_W        destination address travelling with result
//  err_sel      out  1             1-cycle pulse: an illegal select was accepted
//  err_cnt      out  ERR_CW        saturating count of illegal selects
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): buffer emptied; out_valid=0, out_data=0, out_dest=0.
//    Also err_sel=0, err_cnt=0, in_ready=1 the cycle after reset. Reset mid-transfer drops all held entries.
//  - Accept when in_valid&&in_ready. Emit when out_valid&&out_ready.
//  - Latency: accepted bundle appears on out_* on the next cycle when the buffer was empty.
//  - Buffer is a 2-entry FIFO in order (head drives out_*; no combinational in->out path).
//  - in_ready = (count<2), registered. With count==2, out_ready=1 and in_valid=1 at the same edge:
//    pop only. in_ready rises the next cycle, so no accept that cycle.
//  - With count==1, simultaneous accept and pop: count stays 1 and head becomes the new bundle.
//  - out_data/out_dest hold stable while out_valid&&!out_ready.
//  - Select: in_sel<N_SRC selects in_src[in_sel].
//  - Illegal select (in_sel>=N_SRC): result is WIDTH'(0); the bundle still flows with out_valid.
//    err_sel pulses on the cycle after acceptance. err_cnt increments and saturates at all-ones.
//  - An illegal select is counted only when accepted; an offered but stalled bundle does not count.
// CONFIGURATION
//  Macro WB_RESULT_LOAD_EXT_EN.
//  - Defined: extra inputs in_ld_byte (1) and in_ld_signed (1).
//    When in_sel==SRC_MEM and in_ld_byte=1, the result is in_src[SRC_MEM][7:0].
//    It is sign-extended if in_ld_signed, else zero-extended, to WIDTH.
//    Extension is applied before buffering; latency is unchanged.
//  - Undefined: the ports are absent and memory data passes through unmodified.
// STRUCTURE
//  - Package wb_pkg: localparams SRC_ALU=0, SRC_MEM=1, SRC_PC=2; typedef wb_bundle_t {data, dest, err}.
//  - Sub-module wb_skid_buffer (2-entry valid/ready FIFO of wb_bundle_t).
//    Selection and extension logic stays in wb_result_select.
// TESTING
//  1. Reset then idle: out_valid=0, out_data=0, err_cnt=0, in_ready=1.
//  2. Source sweep: src={ALU=16'h1234, MEM=16'hBEEF, PC=16'h0042}, sel=0,1,2, out_ready=1.
//     Expect out_data 1234, BEEF, 0042, each 1 cycle after accept, in order.
//  3. Backpressure: out_ready=0, push 3 bundles. in_ready=0 after 2 accepts; third held at input.
//     Release out_ready: order 1,2,3 preserved and no loss.
//  4. Illegal sel=3 (N_SRC=3), dest=5: out_data=0, out_dest=5, err_sel pulses once, err_cnt=1.
//     Hold err_cnt at 8'hFF, repeat: stays FF.
//  5. Reset mid-operation: buffer full, assert rst_n=0 for one cycle. Next cycle out_valid=0 and in_ready=1.
//  6. (WB_RESULT_LOAD_EXT_EN) MEM=16'h00F0, sel=1, ld_byte=1.
//     signed gives FFF0; unsigned gives 00F0. With ld_byte=0 gives 00F0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback result selector.
// Source indices, default geometry and the bundle that moves through the skid buffer.
package wb_pkg;

    // Default datapath geometry
    localparam int WB_WIDTH  = 16;
    localparam int WB_DEST_W = 3;

    // Source select codes
    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;
    localparam int SRC_PC  = 2;

    // One writeback result: value, target register, and an illegal-select marker
    typedef struct packed {
        logic [WB_WIDTH-1:0]  data;
        logic [WB_DEST_W-1:0] dest;
        logic                 err;
    } wb_bundle_t;

endpackage

// File: rtl/wb_skid_buffer.sv
// Two-entry in-order valid/ready FIFO.
// Entry 0 is always the head and drives the output directly.
// in_ready is a registered "not full" flag, so the upstream path never sees a
// combinational dependency on out_ready.
module wb_skid_buffer
    import wb_pkg::*;
#(
    parameter type bundle_t = wb_bundle_t
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    in_valid,
    output logic    in_ready,
    input  bundle_t in_bundle,
    output logic    out_valid,
    input  logic    out_ready,
    output bundle_t out_bundle
);

    logic [1:0] count_q, count_d;
    logic       in_ready_q, in_ready_d;
    bundle_t    entry_q [2];
    bundle_t    entry_d [2];
    logic       push, pop;

    assign push = in_valid && in_ready_q;
    assign pop  = (count_q != 2'd0) && out_ready;

    // Next-state for occupancy and entries; pops shift entry 1 into the head
    always_comb begin
        count_d    = count_q;
        entry_d[0] = entry_q[0];
        entry_d[1] = entry_q[1];
        if (push && pop) begin
            // Only reachable with one entry held: new bundle replaces the head
            entry_d[0] = in_bundle;
        end else if (pop) begin
            entry_d[0] = entry_q[1];
            count_d    = count_q - 2'd1;
        end else if (push) begin
            if (count_q == 2'd0) begin
                entry_d[0] = in_bundle;
            end else begin
                entry_d[1] = in_bundle;
            end
            count_d = count_q + 2'd1;
        end
        in_ready_d = (count_d != 2'd2);
    end

    // Occupancy and ready flag; reset empties the buffer and opens the input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Entry storage, cleared on reset so the idle output reads zero
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                entry_q[gi] <= '0;
            end else begin
                entry_q[gi] <= entry_d[gi];
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (count_q != 2'd0);
    assign out_bundle = entry_q[0];

endmodule

// File: rtl/wb_result_select.sv
// Pipelined writeback result selector.
// Picks one of N_SRC sources by in_sel, tags it with its destination register and
// passes it through a 2-entry skid buffer toward the register bank.
// Illegal select codes yield a zero result, raise a one-cycle err_sel pulse and bump
// a saturating error counter, counted only on acceptance.
// Optional feature macro: WB_RESULT_LOAD_EXT_EN adds byte-load sign/zero extension
// on the memory source (ports in_ld_byte, in_ld_signed).
module wb_result_select
    import wb_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int N_SRC  = 3,
    parameter int SEL_W  = 2,
    parameter int DEST_W = 3,
    parameter int ERR_CW = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic [N_SRC*WIDTH-1:0] in_src,
    input  logic [DEST_W-1:0]      in_dest,
`ifdef WB_RESULT_LOAD_EXT_EN
    input  logic                   in_ld_byte,
    input  logic                   in_ld_signed,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [DEST_W-1:0]      out_dest,
    output logic                   err_sel,
    output logic [ERR_CW-1:0]      err_cnt
);

    // Bundle sized to this instance's parameters
    typedef struct packed {
        logic [WIDTH-1:0]  data;
        logic [DEST_W-1:0] dest;
        logic              err;
    } bundle_t;

    logic [WIDTH-1:0]  src_arr [N_SRC];
    logic [WIDTH-1:0]  sel_data;
    logic [WIDTH-1:0]  result;
    logic              sel_illegal;
    logic              accept;
    bundle_t           in_bundle;
    bundle_t           out_bundle;
    logic              buf_in_ready;

    logic              err_sel_q, err_sel_d;
    logic [ERR_CW-1:0] err_cnt_q, err_cnt_d;

    // Unpack the flat source bus into one word per source
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        assign src_arr[gi] = in_src[gi*WIDTH +: WIDTH];
    end

    // Source multiplexer; out-of-range codes produce zero
    always_comb begin
        sel_illegal = (int'(in_sel) >= N_SRC);
        sel_data    = '0;
        if (!sel_illegal) begin
            sel_data = src_arr[in_sel];
        end
    end

`ifdef WB_RESULT_LOAD_EXT_EN
    // Byte-load extension of memory data, applied before buffering
    always_comb begin
        result = sel_data;
        if ((int'(in_sel) == SRC_MEM) && in_ld_byte) begin
            if (in_ld_signed) begin
                result = {{(WIDTH-8){sel_data[7]}}, sel_data[7:0]};
            end else begin
                result = {{(WIDTH-8){1'b0}}, sel_data[7:0]};
            end
        end
    end
`else
    // Memory data passes through unmodified
    always_comb begin
        result = sel_data;
    end
`endif

    assign in_bundle.data = result;
    assign in_bundle.dest = in_dest;
    assign in_bundle.err  = sel_illegal;

    assign accept = in_valid && buf_in_ready;

    wb_skid_buffer #(
        .bundle_t (bundle_t)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (buf_in_ready),
        .in_bundle  (in_bundle),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bundle (out_bundle)
    );

    // Error pulse and saturating counter, driven only by accepted illegal selects
    always_comb begin
        err_sel_d = accept && sel_illegal;
        err_cnt_d = err_cnt_q;
        if (err_sel_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Error state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sel_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_sel_q <= err_sel_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign in_ready = buf_in_ready;
    assign out_data = out_bundle.data;
    assign out_dest = out_bundle.dest;
    assign err_sel  = err_sel_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_wb_result_select.sv
// Directed self-checking bench for wb_result_select (default geometry, N_SRC=3).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_wb_result_select;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [47:0] in_src;
    logic [2:0]  in_dest;
`ifdef WB_RESULT_LOAD_EXT_EN
    logic        in_ld_byte;
    logic        in_ld_signed;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_dest;
    logic        err_sel;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;

    wb_result_select #(
        .WIDTH  (16),
        .N_SRC  (3),
        .SEL_W  (2),
        .DEST_W (3),
        .ERR_CW (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sel       (in_sel),
        .in_src       (in_src),
        .in_dest      (in_dest),
`ifdef WB_RESULT_LOAD_EXT_EN
        .in_ld_byte   (in_ld_byte),
        .in_ld_signed (in_ld_signed),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_dest     (out_dest),
        .err_sel      (err_sel),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[%0t] %s observed=%h expected=%h", $time, tag, obs, exp);
    endtask

    // Advance one clock and land on the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_src    = '0;
        in_dest   = 3'd0;
        out_ready = 1'b0;
`ifdef WB_RESULT_LOAD_EXT_EN
        in_ld_byte   = 1'b0;
        in_ld_signed = 1'b0;
`endif
        @(negedge clk);
        step();
        rst_n = 1'b1;

        // 1. Reset then idle
        step();
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_data",  32'(out_data),  32'h0);
        chk("reset_out_dest",  32'(out_dest),  32'h0);
        chk("reset_err_cnt",   32'(err_cnt),   32'h0);
        chk("reset_err_sel",   32'(err_sel),   32'h0);
        chk("reset_in_ready",  32'(in_ready),  32'h1);

        // 2. Source sweep, one accept per cycle, one-cycle latency
        in_src    = {16'h0042, 16'hBEEF, 16'h1234};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sel = 2'd0; in_dest = 3'd1;
        step();
        chk("sweep_alu_valid", 32'(out_valid), 32'h1);
        chk("sweep_alu_data",  32'(out_data),  32'h1234);
        chk("sweep_alu_dest",  32'(out_dest),  32'h1);
        in_sel = 2'd1; in_dest = 3'd2;
        step();
        chk("sweep_mem_data",  32'(out_data),  32'hBEEF);
        chk("sweep_mem_dest",  32'(out_dest),  32'h2);
        in_sel = 2'd2; in_dest = 3'd3;
        step();
        chk("sweep_pc_data",   32'(out_data),  32'h0042);
        chk("sweep_pc_dest",   32'(out_dest),  32'h3);
        chk("sweep_no_err",    32'(err_cnt),   32'h0);
        in_valid = 1'b0;
        step();
        chk("sweep_drained",   32'(out_valid), 32'h0);

        // 3. Backpressure: three bundles with out_ready low
        out_ready = 1'b0;
        in_sel    = 2'd0;
        in_valid  = 1'b1;
        in_src[15:0] = 16'hA001; in_dest = 3'd1;
        step();
        chk("bp_ready_after1", 32'(in_ready), 32'h1);
        chk("bp_head1",        32'(out_data), 32'hA001);
        in_src[15:0] = 16'hA002; in_dest = 3'd2;
        step();
        chk("bp_ready_full",   32'(in_ready), 32'h0);
        in_src[15:0] = 16'hA003; in_dest = 3'd3;
        step();
        chk("bp_still_full",   32'(in_ready), 32'h0);
        chk("bp_head_stable",  32'(out_data), 32'hA001);
        chk("bp_dest_stable",  32'(out_dest), 32'h1);
        out_ready = 1'b1;
        step();
        chk("bp_pop1_data",    32'(out_data), 32'hA002);
        chk("bp_pop1_ready",   32'(in_ready), 32'h1);
        step();
        chk("bp_third_data",   32'(out_data), 32'hA003);
        chk("bp_third_dest",   32'(out_dest), 32'h3);
        chk("bp_third_valid",  32'(out_valid), 32'h1);
        in_valid = 1'b0;
        step();
        chk("bp_empty",        32'(out_valid), 32'h0);

        // 4. Illegal select
        in_sel = 2'd3; in_dest = 3'd5; in_valid = 1'b1;
        step();
        chk("ill_valid",   32'(out_valid), 32'h1);
        chk("ill_data",    32'(out_data),  32'h0);
        chk("ill_dest",    32'(out_dest),  32'h5);
        chk("ill_err_sel", 32'(err_sel),   32'h1);
        chk("ill_err_cnt", 32'(err_cnt),   32'h1);
        in_valid = 1'b0;
        step();
        chk("ill_pulse_end", 32'(err_sel), 32'h0);
        chk("ill_cnt_hold",  32'(err_cnt), 32'h1);

        // Stalled illegal bundle must not count
        out_ready = 1'b0;
        in_sel = 2'd0; in_valid = 1'b1;
        step();
        step();
        in_sel = 2'd3;
        step();
        step();
        chk("stall_no_count", 32'(err_cnt), 32'h1);
        chk("stall_no_pulse", 32'(err_sel), 32'h0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("stall_drained", 32'(out_valid), 32'h0);

        // Saturation: 254 more accepted illegal selects reach FF, then hold
        in_sel = 2'd3; in_valid = 1'b1;
        for (int i = 0; i < 254; i++) step();
        chk("sat_reach_ff", 32'(err_cnt), 32'hFF);
        step();
        step();
        chk("sat_hold_ff",  32'(err_cnt), 32'hFF);
        chk("sat_pulse",    32'(err_sel), 32'h1);
        in_valid = 1'b0;
        step();
        step();

        // 5. Reset with a full buffer
        out_ready = 1'b0;
        in_sel = 2'd0; in_src[15:0] = 16'hC0DE; in_valid = 1'b1;
        step();
        step();
        chk("rst_pre_full", 32'(in_ready), 32'h0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_mid_valid",   32'(out_valid), 32'h0);
        chk("rst_mid_ready",   32'(in_ready),  32'h1);
        chk("rst_mid_err_cnt", 32'(err_cnt),   32'h0);
        chk("rst_mid_data",    32'(out_data),  32'h0);

`ifdef WB_RESULT_LOAD_EXT_EN
        // 6. Byte-load extension on the memory source
        out_ready = 1'b1;
        in_src = {16'h0042, 16'h00F0, 16'h1234};
        in_sel = 2'd1; in_dest = 3'd4; in_valid = 1'b1;
        in_ld_byte = 1'b1; in_ld_signed = 1'b1;
        step();
        chk("ext_signed",   32'(out_data), 32'hFFF0);
        in_ld_signed = 1'b0;
        step();
        chk("ext_unsigned", 32'(out_data), 32'h00F0);
        in_ld_byte = 1'b0; in_ld_signed = 1'b1;
        step();
        chk("ext_word",     32'(out_data), 32'h00F0);
        in_sel = 2'd0; in_ld_byte = 1'b1;
        step();
        chk("ext_alu_untouched", 32'(out_data), 32'h1234);
        in_valid = 1'b0;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
